clk_div_multi: RTL and testbench

- Parametrised multi-channel successor of the processor's single-rate clock divider.
- Each channel derives a divided clock and a one-cycle tick from the system clock. The division rate of each channel is programmable at run time.
- Each channel has a halt that parks the output high, so a downstream core can freeze in a known phase.
- Sits between the board clock and the MIPS core and its peripherals; also serves as the clock source for a debug single-step path.

---
 rtl/clk_div_multi.sv | 91 +++++++++
 tb/tb_clk_div_multi.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel halt; optional single-step via DIV_STEP_EN.
// Latency: div_clk toggles on the edge where count reaches the divisor; tick is registered alongside the rising toggle.
// Backpressure: none; halt parks a channel high, and divisor writes wait in a shadow until the next toggle.
module clk_div_multi #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 2500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [NUM_CH-1:0] halt,
    input  logic [NUM_CH-1:0] step,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] halted
);

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

`ifndef DIV_STEP_EN
    logic unused_step;
    assign unused_step = &{1'b0, step};
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act;
        logic [CNT_W-1:0] shd;
        logic             dclk;
        logic             tck;
        logic             frozen;
        logic             hit;
        logic             wr_hit;

        // Channels at or above NUM_CH never match, so out-of-range writes drop.
        assign wr_hit = wr_en && (wr_ch == 3'(g));
        assign hit    = (cnt == act);

`ifdef DIV_STEP_EN
        logic grant;

        assign frozen = halt[g] && dclk && !grant;

        // A grant lasts until the rising toggle that completes the stepped period.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                grant <= 1'b0;
            end else if (frozen && step[g]) begin
                grant <= 1'b1;
            end else if (grant && hit && !dclk) begin
                grant <= 1'b0;
            end
        end
`else
        assign frozen = halt[g] && dclk;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt  <= '0;
                act  <= DEF;
                shd  <= DEF;
                dclk <= 1'b1;
                tck  <= 1'b0;
            end else begin
                tck <= 1'b0;
                if (wr_hit) begin
                    shd <= wr_div;
                end
                if (!frozen) begin
                    if (hit) begin
                        cnt  <= '0;
                        dclk <= ~dclk;
                        act  <= shd;
                        tck  <= ~dclk;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign div_clk[g] = dclk;
        assign tick[g]    = tck;
        assign halted[g]  = frozen;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with NUM_CH=2, DEF_DIV=3; expected values are hand-derived edge by edge.
module tb_clk_div_multi;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [15:0] wr_div;
    logic [1:0]  halt;
    logic [1:0]  step;
    logic [1:0]  div_clk;
    logic [1:0]  tick;
    logic [1:0]  halted;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_multi #(
        .NUM_CH (2),
        .CNT_W  (16),
        .DEF_DIV(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .halt   (halt),
        .step   (step),
        .div_clk(div_clk),
        .tick   (tick),
        .halted (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = 3'd0;
        wr_div = 16'd0;
        halt   = 2'b00;
        step   = 2'b00;

        // Reset state
        cyc(2);
        chk("rst_div_clk", div_clk, 2'b11);
        chk("rst_tick", tick, 2'b00);
        chk("rst_halted", halted, 2'b00);

        // Reset release: fall at edge 4, rise at edge 8
        reset = 1'b1;
        cyc(3);
        chk("t1_e3_high", div_clk, 2'b11);
        cyc(1);
        chk("t1_e4_fall", div_clk, 2'b00);
        cyc(3);
        chk("t1_e7_low", div_clk, 2'b00);
        cyc(1);
        chk("t1_e8_rise", div_clk, 2'b11);
        chk("t1_e8_tick", tick, 2'b11);
        cyc(1);
        chk("t1_e9_tick_off", tick, 2'b00);
        chk("t1_e9_high", div_clk, 2'b11);

        // Mid-half-period write of divisor 0 to ch0
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 16'd0;
        cyc(1);
        wr_en = 1'b0;
        chk("t2_e10_high", div_clk, 2'b11);
        cyc(2);
        chk("t2_e12_fall", div_clk, 2'b00);
        cyc(1);
        chk("t2_e13_ch0_rise", div_clk, 2'b01);
        chk("t2_e13_tick", tick, 2'b01);
        cyc(1);
        chk("t2_e14_ch0_fall", div_clk, 2'b00);
        chk("t2_e14_tick", tick, 2'b00);
        cyc(1);
        chk("t2_e15", div_clk, 2'b01);
        cyc(1);
        chk("t2_e16_ch1_rise", div_clk, 2'b10);
        chk("t2_e16_tick", tick, 2'b10);

        // Halt ch1 during its low phase
        cyc(4);
        chk("t3_e20_ch1_low", div_clk & 2'b10, 2'b00);
        halt = 2'b10;
        cyc(3);
        chk("t3_e23_still_low", div_clk & 2'b10, 2'b00);
        chk("t3_e23_not_halted", halted, 2'b00);
        cyc(1);
        chk("t3_e24_rise", div_clk & 2'b10, 2'b10);
        chk("t3_e24_tick", tick & 2'b10, 2'b10);
        chk("t3_e24_halted", halted, 2'b10);
        cyc(1);
        chk("t3_e25_tick_off", tick & 2'b10, 2'b00);
        chk("t3_e25_both", div_clk, 2'b11);
        chk("t3_e25_halted", halted, 2'b10);
        cyc(19);
        chk("t3_e44_held", div_clk & 2'b10, 2'b10);
        chk("t3_e44_halted", halted, 2'b10);
        halt = 2'b00;
        cyc(3);
        chk("t3_e47_high", div_clk & 2'b10, 2'b10);
        chk("t3_e47_released", halted, 2'b00);
        cyc(1);
        chk("t3_e48_fall", div_clk & 2'b10, 2'b00);

        // Out-of-range channel write must change nothing
        wr_en = 1'b1; wr_ch = 3'd5; wr_div = 16'd5;
        cyc(1);
        wr_en = 1'b0;
        cyc(3);
        chk("t5_e52_rise", div_clk & 2'b10, 2'b10);
        chk("t5_e52_tick", tick & 2'b10, 2'b10);
        cyc(3);
        chk("t5_e55", div_clk, 2'b11);
        cyc(1);
        chk("t5_e56_fall", div_clk, 2'b00);

        // Reset asserted mid-low-phase
        cyc(2);
        reset = 1'b0;
        #1;
        chk("t4_async_div_clk", div_clk, 2'b11);
        chk("t4_async_tick", tick, 2'b00);
        chk("t4_async_halted", halted, 2'b00);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        chk("t4_e3_high", div_clk, 2'b11);

        // Write ch0 divisor 1 in the same cycle as the toggle: applies one toggle later
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 16'd1;
        cyc(1);
        wr_en = 1'b0;
        chk("t4_e4_fall", div_clk, 2'b00);
        cyc(3);
        chk("tw_e7_low", div_clk, 2'b00);
        cyc(1);
        chk("tw_e8_rise", div_clk, 2'b11);
        chk("tw_e8_tick", tick, 2'b11);
        cyc(1);
        chk("tw_e9_high", div_clk, 2'b11);
        cyc(1);
        chk("tw_e10_ch0_fall", div_clk, 2'b10);

`ifdef DIV_STEP_EN
        // Single step on a frozen ch0
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        halt = 2'b01;
        #1;
        chk("t6_frozen", halted & 2'b01, 2'b01);
        cyc(1);
        chk("t6_e1_frozen", halted & 2'b01, 2'b01);
        step = 2'b01;
        cyc(1);
        step = 2'b00;
        chk("t6_s0_granted", halted & 2'b01, 2'b00);
        chk("t6_s0_high", div_clk & 2'b01, 2'b01);
        cyc(1);
        step = 2'b01;
        cyc(1);
        step = 2'b00;
        cyc(1);
        chk("t6_s3_high", div_clk & 2'b01, 2'b01);
        cyc(1);
        chk("t6_s4_fall", div_clk & 2'b01, 2'b00);
        cyc(3);
        chk("t6_s7_low", div_clk & 2'b01, 2'b00);
        cyc(1);
        chk("t6_s8_rise", div_clk & 2'b01, 2'b01);
        chk("t6_s8_tick", tick & 2'b01, 2'b01);
        chk("t6_s8_refrozen", halted & 2'b01, 2'b01);
        cyc(4);
        chk("t6_s12_held", div_clk & 2'b01, 2'b01);
        chk("t6_s12_halted", halted & 2'b01, 2'b01);
        chk("t6_s12_tick", tick & 2'b01, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
